// File: rtl/gpu_text_pkg.sv
// Shared opcodes, FSM encoding and fill constants for the text-mode command processor.
package gpu_text_pkg;
  localparam logic [15:0] OP_RESET = 16'h00C0;
  localparam logic [15:0] OP_PUT   = 16'h00C1;
  localparam logic [15:0] OP_BS    = 16'h00C2;
  localparam logic [15:0] OP_SETY  = 16'h00C3;
  localparam logic [15:0] OP_SETX  = 16'h00C4;
  localparam logic [15:0] OP_CLEAR = 16'h00C5;
  localparam logic [15:0] OP_NL    = 16'h00C6;
  localparam logic [15:0] OP_ATTR  = 16'h00C7;

  localparam logic [7:0] BLANK_CHAR   = 8'h20;
  localparam logic [7:0] ATTR_DEFAULT = 8'h07;

  typedef enum logic [1:0] {ST_OP, ST_PARAM, ST_EXEC, ST_FILL} state_t;
endpackage

// File: rtl/text_ram.sv
// Character cell store: one write port, one registered read port (read-first on collision).
module text_ram #(
  parameter int DEPTH = 1000,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk)
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
endmodule

// File: rtl/gpu_text_ctrl.sv
// Text-mode command processor: two-word commands, cursor, row-base scrolling, blank fills.
// Optional per-cell attribute storage enabled by defining GPU_TEXT_ATTR_EN.
module gpu_text_ctrl
  import gpu_text_pkg::*;
#(
  parameter int COLS   = 40,
  parameter int ROWS   = 25,
  parameter int CHAR_W = 8,
  parameter int ATTR_W = 8,
  parameter int WORD_W = 16,
`ifdef GPU_TEXT_ATTR_EN
  localparam int CELL_W = CHAR_W + ATTR_W,
`else
  localparam int CELL_W = CHAR_W,
`endif
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WORD_W-1:0] cmd_data,
  output logic              busy,
  output logic [XW-1:0]     cursor_x,
  output logic [YW-1:0]     cursor_y,
  input  logic [XW-1:0]     rd_col,
  input  logic [YW-1:0]     rd_row,
  output logic [CELL_W-1:0] rd_data
);
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [XW-1:0] COLS_M1 = XW'(COLS - 1);
  localparam logic [YW-1:0] ROWS_M1 = YW'(ROWS - 1);
  localparam logic [YW:0]   ROWS_P  = (YW+1)'(ROWS);
  localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(BLANK_CHAR);

  state_t            state, state_n;
  logic [WORD_W-1:0] opc, opc_n, prm, prm_n;
  logic [XW-1:0]     x, x_n;
  logic [YW-1:0]     y, y_n, base, base_n;
  logic [AW-1:0]     faddr, faddr_n, flast, flast_n;
  logic              we, adv;
  logic [AW-1:0]     waddr;
  logic [CELL_W-1:0] wdata, blank_cell;
`ifdef GPU_TEXT_ATTR_EN
  logic [ATTR_W-1:0] attr, attr_n;
  assign blank_cell = {attr, BLANK};
`else
  assign blank_cell = BLANK;
`endif

  // Screen row to physical row via a single compare-and-subtract, then linear address.
  function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] col,
                                              input logic [YW-1:0] row,
                                              input logic [YW-1:0] rb);
    logic [YW:0] p;
    p = {1'b0, row} + {1'b0, rb};
    if (p >= ROWS_P) p = p - ROWS_P;
    return AW'(p) * AW'(COLS) + AW'(col);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FILL;
      opc   <= '0;
      prm   <= '0;
      x     <= '0;
      y     <= '0;
      base  <= '0;
      faddr <= '0;
      flast <= AW'(DEPTH - 1);
`ifdef GPU_TEXT_ATTR_EN
      attr  <= ATTR_W'(ATTR_DEFAULT);
`endif
    end else begin
      state <= state_n;
      opc   <= opc_n;
      prm   <= prm_n;
      x     <= x_n;
      y     <= y_n;
      base  <= base_n;
      faddr <= faddr_n;
      flast <= flast_n;
`ifdef GPU_TEXT_ATTR_EN
      attr  <= attr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    opc_n   = opc;
    prm_n   = prm;
    x_n     = x;
    y_n     = y;
    base_n  = base;
    faddr_n = faddr;
    flast_n = flast;
`ifdef GPU_TEXT_ATTR_EN
    attr_n  = attr;
`endif
    we      = 1'b0;
    waddr   = faddr;
    wdata   = blank_cell;
    adv     = 1'b0;
    case (state)
      ST_OP:    if (cmd_valid) begin opc_n = cmd_data; state_n = ST_PARAM; end
      ST_PARAM: if (cmd_valid) begin prm_n = cmd_data; state_n = ST_EXEC; end
      ST_EXEC: begin
        state_n = ST_OP;
        case (opc)
          OP_RESET, OP_CLEAR: begin
            base_n  = '0;
            x_n     = '0;
            y_n     = '0;
            faddr_n = '0;
            flast_n = AW'(DEPTH - 1);
            state_n = ST_FILL;
`ifdef GPU_TEXT_ATTR_EN
            if (opc == OP_RESET) attr_n = ATTR_W'(ATTR_DEFAULT);
`endif
          end
          OP_PUT: begin
            we    = 1'b1;
            waddr = cell_addr(x, y, base);
`ifdef GPU_TEXT_ATTR_EN
            wdata = {attr, prm[CHAR_W-1:0]};
`else
            wdata = prm[CHAR_W-1:0];
`endif
            if (x == COLS_M1) begin x_n = '0; adv = 1'b1; end
            else x_n = x + XW'(1);
          end
          OP_BS: if (x != '0 || y != '0) begin
            if (x == '0) begin x_n = COLS_M1; y_n = y - YW'(1); end
            else x_n = x - XW'(1);
            we    = 1'b1;
            waddr = cell_addr(x_n, y_n, base);
          end
          OP_SETY: y_n = (prm >= WORD_W'(ROWS)) ? ROWS_M1 : prm[YW-1:0];
          OP_SETX: x_n = (prm >= WORD_W'(COLS)) ? COLS_M1 : prm[XW-1:0];
          OP_NL: begin x_n = '0; adv = 1'b1; end
`ifdef GPU_TEXT_ATTR_EN
          OP_ATTR: attr_n = prm[ATTR_W-1:0];
`endif
          default: ;
        endcase
        // Scrolling: the old top physical row becomes the new bottom and is blanked.
        if (adv) begin
          if (y == ROWS_M1) begin
            base_n  = (base == ROWS_M1) ? '0 : base + YW'(1);
            faddr_n = cell_addr('0, '0, base);
            flast_n = faddr_n + AW'(COLS - 1);
            state_n = ST_FILL;
          end else y_n = y + YW'(1);
        end
      end
      ST_FILL: begin
        we      = 1'b1;
        faddr_n = faddr + AW'(1);
        if (faddr == flast) state_n = ST_OP;
      end
      default: state_n = ST_OP;
    endcase
  end

  assign cmd_ready = (state == ST_OP) || (state == ST_PARAM);
  assign busy      = (state == ST_EXEC) || (state == ST_FILL);
  assign cursor_x  = x;
  assign cursor_y  = y;

  text_ram #(.DEPTH(DEPTH), .AW(AW), .DW(CELL_W)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we & ~reset),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (cell_addr(rd_col, rd_row, base)),
    .rdata (rd_data)
  );
endmodule

// File: doc/gpu_text_ctrl.md
# gpu_text_ctrl

Parametrised text-mode command processor for the GPU. It takes the CPU's 16-bit command/parameter word stream, maintains a COLS×ROWS character buffer with cursor, and serves a registered read port to the VGA character scanner. Over the 40×25 fixed-size generation it adds configurable geometry, a valid/ready handshake, multi-cycle clear/fill, and hardware scrolling through a row-base offset.

## Interface
- COLS, 40, characters per row (≥2)
- ROWS, 25, rows per screen (≥2)
- CHAR_W, 8, bits per character code
- ATTR_W, 8, bits per attribute (used only with GPU_TEXT_ATTR_EN)
- WORD_W, 16, CPU command word width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  cmd_data holds a word
- cmd_ready  out  1  word accepted when cmd_valid && cmd_ready
- cmd_data  in  WORD_W  opcode or parameter word
- busy  out  1  executing or filling
- cursor_x  out  clog2(COLS)  current column
- cursor_y  out  clog2(ROWS)  current screen row
- rd_col  in  clog2(COLS)  scanner column
- rd_row  in  clog2(ROWS)  scanner screen row (0 = top)
- rd_data  out  CHAR_W (+ATTR_W)  cell contents, attribute in upper bits

## Operation
- Every command is two words: opcode, then parameter (ignored by commands without one).
- Opcodes: 0x00C0 soft reset (=clear, attr to default); 0x00C1 put char param[CHAR_W-1:0]; 0x00C2 backspace; 0x00C3 set Y; 0x00C4 set X; 0x00C5 clear screen; 0x00C6 newline; 0x00C7 set attribute (macro only). Any other opcode: param consumed, no effect.
- FSM: OP (ready=1) → PARAM (ready=1) → EXEC (ready=0, 1 cycle) → OP, or → FILL (ready=0) → OP.
- Put char: write cell at cursor; x+1; at x=COLS-1 wraps to x=0, y+1.
- Newline: x=0, y+1.
- Row advance past ROWS-1: scroll — row_base = (row_base+1) mod ROWS, y stays ROWS-1, new bottom row filled with 0x20 in FILL (COLS cycles).
- Backspace: at (0,0) no-op; at x=0 → (COLS-1, y-1); else x-1; new cursor cell written 0x20.
- Set X / set Y: value ≥ COLS / ≥ ROWS clamps to COLS-1 / ROWS-1; cursor only, no write.
- Clear / soft reset: row_base=0, cursor (0,0), FILL all ROWS·COLS cells with 0x20 (one per cycle).
- Physical row = (screen row + row_base) mod ROWS, by compare-and-subtract, no divide; address = phys_row·COLS + col.
- reset: cursor 0, row_base 0, FSM enters FILL for full-screen clear.

## Timing
- Reset values: cmd_ready 0, busy 1, cursor_x 0, cursor_y 0, rd_data 0; full clear starts first cycle after reset deasserts.
- Opcode accepted cycle n, param cycle m≥n+1; EXEC cycle m+1 writes RAM; cursor outputs and cmd_ready=1 at m+2 unless FILL.
- FILL: COLS or ROWS·COLS cycles; cmd_ready returns the cycle after last cell write.
- Peak throughput one command per 3 cycles.
- rd_data: 1-cycle latency, read-first on same-cell write collision.
- cmd_valid low between opcode and param: FSM waits in PARAM indefinitely.
- reset mid-command or mid-FILL: command discarded, full clear restarts.

## Configuration
- GPU_TEXT_ATTR_EN defined: cell width CHAR_W+ATTR_W; 0x00C7 latches param[ATTR_W-1:0] as current attribute (reset/soft reset default 0x07); put char and fills store current attribute.
- Undefined: cells CHAR_W only; 0x00C7 treated as unknown opcode; rd_data width CHAR_W.

## Structure
- gpu_text_pkg: opcode localparams, FSM state enum, BLANK_CHAR=8'h20, ATTR_DEFAULT=8'h07.
- Sub-module text_ram: simple dual-port RAM, one write port, one registered read port, depth ROWS·COLS.

## Test plan
- Reset, wait for busy=0 → every cell reads 0x20, cursor (0,0), cmd_ready=1.
- C1/0x41 at default geometry → cell (0,0)=0x41, cursor (1,0), cmd_ready back 2 cycles after param.
- C4/39 then C1/0x42 → cell (39,0)=0x42, cursor (0,1); C4/99 → cursor_x=39.
- C3/24, C6 → busy for 40 cycles, screen row 0 shows former row 1, row 24 all 0x20, cursor (0,24).
- C2 at (0,0) → no change; C2 at (0,5) → cursor (39,4), that cell 0x20.
- Assert reset during a C5 fill → fill restarts, cursor (0,0), all cells 0x20 after 1000 cycles.
